// File: rtl/leaf_tri_fetch.sv
// Leaf triangle fetch: takes one BVH leaf descriptor, streams each triangle's words from the scene ROM
// and hands out one assembled triangle per transfer. Optional counters when LEAF_TRI_FETCH_STATS_EN is defined.
module leaf_tri_fetch #(
    parameter int ADDR_W        = 17,
    parameter int DATA_W        = 32,
    parameter int WORDS_PER_TRI = 9,
    parameter int TRI_BASE_ADDR = 0,
    parameter int CNT_W         = 4,
    parameter int IDX_W         = 16,
    parameter int RAY_W         = 8,
    parameter int ROM_LAT       = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              leaf_valid,
    output logic                              leaf_ready,
    input  logic [RAY_W-1:0]                  leaf_ray_id,
    input  logic [IDX_W-1:0]                  leaf_tri_base,
    input  logic [CNT_W-1:0]                  leaf_tri_count,
    output logic [ADDR_W-1:0]                 rom_addr,
    output logic                              rom_rden,
    input  logic [DATA_W-1:0]                 rom_q,
    output logic                              tri_valid,
    input  logic                              tri_ready,
    output logic [WORDS_PER_TRI*DATA_W-1:0]   tri_data,
    output logic [IDX_W-1:0]                  tri_id,
    output logic [RAY_W-1:0]                  tri_ray_id,
    output logic                              tri_last
`ifdef LEAF_TRI_FETCH_STATS_EN
    ,
    output logic [31:0]                       stat_tris,
    output logic [31:0]                       stat_leaves,
    output logic [31:0]                       stat_stall
`endif
);

    localparam int KW = (WORDS_PER_TRI > 1) ? $clog2(WORDS_PER_TRI) : 1;
    localparam logic [KW-1:0]    K_LAST  = KW'(WORDS_PER_TRI - 1);
    localparam logic [KW-1:0]    K_ONE   = KW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT
    } state_t;

    state_t state_q, state_d;

    logic [RAY_W-1:0]  ray_q, ray_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  i_q, i_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_rden_q, rom_rden_d;
    logic [KW-1:0]     iss_k_q, iss_k_d;
    logic [ROM_LAT-1:0] vld_q, vld_d;
    logic [KW-1:0]     kidx_q [ROM_LAT];
    logic [KW-1:0]     kidx_d [ROM_LAT];
    logic [DATA_W-1:0] words_q [WORDS_PER_TRI];
    logic [DATA_W-1:0] words_d [WORDS_PER_TRI];

    logic          cap;
    logic [KW-1:0] cap_k;
    logic          last_tri;

    // First word address of a triangle; all arithmetic is modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] tri_addr(input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(idx);
        return ADDR_W'(TRI_BASE_ADDR) + a * ADDR_W'(WORDS_PER_TRI);
    endfunction

    assign cap      = vld_q[ROM_LAT-1];
    assign cap_k    = kidx_q[ROM_LAT-1];
    assign last_tri = (i_q == (cnt_q - CNT_ONE));

    always_comb begin
        state_d    = state_q;
        ray_d      = ray_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        i_d        = i_q;
        rom_addr_d = rom_addr_q;
        rom_rden_d = 1'b0;
        iss_k_d    = iss_k_q;
        words_d    = words_q;

        // Read-return tracker: tags each issued address with its word slot until the data arrives.
        vld_d[0]  = rom_rden_q;
        kidx_d[0] = iss_k_q;
        for (int unsigned j = 1; j < ROM_LAT; j++) begin
            vld_d[j]  = vld_q[j-1];
            kidx_d[j] = kidx_q[j-1];
        end

        if (cap) begin
            words_d[cap_k] = rom_q;
        end

        case (state_q)
            S_IDLE: begin
                if (leaf_valid) begin
                    ray_d = leaf_ray_id;
                    cur_d = leaf_tri_base;
                    cnt_d = leaf_tri_count;
                    i_d   = '0;
                    if (leaf_tri_count != '0) begin
                        state_d    = S_FETCH;
                        rom_rden_d = 1'b1;
                        rom_addr_d = tri_addr(leaf_tri_base);
                        iss_k_d    = '0;
                    end
                end
            end
            S_FETCH: begin
                if (rom_rden_q && (iss_k_q != K_LAST)) begin
                    rom_rden_d = 1'b1;
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    iss_k_d    = iss_k_q + K_ONE;
                end
                if (cap && (cap_k == K_LAST)) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (tri_ready) begin
                    if (last_tri) begin
                        state_d = S_IDLE;
                    end else begin
                        // Address register is loaded here so the next fetch issues in the following cycle.
                        state_d    = S_FETCH;
                        cur_d      = cur_q + IDX_ONE;
                        i_d        = i_q + CNT_ONE;
                        rom_rden_d = 1'b1;
                        rom_addr_d = tri_addr(cur_q + IDX_ONE);
                        iss_k_d    = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ray_q      <= '0;
            cur_q      <= '0;
            cnt_q      <= '0;
            i_q        <= '0;
            rom_addr_q <= '0;
            rom_rden_q <= 1'b0;
            iss_k_q    <= '0;
            vld_q      <= '0;
            kidx_q     <= '{default: '0};
            words_q    <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ray_q      <= ray_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            i_q        <= i_d;
            rom_addr_q <= rom_addr_d;
            rom_rden_q <= rom_rden_d;
            iss_k_q    <= iss_k_d;
            vld_q      <= vld_d;
            kidx_q     <= kidx_d;
            words_q    <= words_d;
        end
    end

    assign leaf_ready = (state_q == S_IDLE);
    assign tri_valid  = (state_q == S_EMIT);
    assign tri_last   = tri_valid && last_tri;
    assign tri_id     = cur_q;
    assign tri_ray_id = ray_q;
    assign rom_addr   = rom_addr_q;
    assign rom_rden   = rom_rden_q;

    always_comb begin
        tri_data = '0;
        for (int unsigned k = 0; k < WORDS_PER_TRI; k++) begin
            tri_data[DATA_W*k +: DATA_W] = words_q[k];
        end
    end

`ifdef LEAF_TRI_FETCH_STATS_EN
    logic [31:0] stat_tris_q, stat_tris_d;
    logic [31:0] stat_leaves_q, stat_leaves_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_tris_d   = stat_tris_q;
        stat_leaves_d = stat_leaves_q;
        stat_stall_d  = stat_stall_q;
        if (tri_valid && tri_ready && (stat_tris_q != '1)) begin
            stat_tris_d = stat_tris_q + 32'd1;
        end
        if (leaf_ready && leaf_valid && (stat_leaves_q != '1)) begin
            stat_leaves_d = stat_leaves_q + 32'd1;
        end
        if (tri_valid && !tri_ready && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_tris_q   <= '0;
            stat_leaves_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_tris_q   <= stat_tris_d;
            stat_leaves_q <= stat_leaves_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_tris   = stat_tris_q;
    assign stat_leaves = stat_leaves_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_leaf_tri_fetch.sv
// Scoreboard bench for leaf_tri_fetch: ROM model with 2-cycle latency, expected triangles queued at
// descriptor accept and popped by an independent monitor on each transfer.
module tb_leaf_tri_fetch;

    localparam int ADDR_W        = 17;
    localparam int DATA_W        = 32;
    localparam int WORDS_PER_TRI = 9;
    localparam int TRI_BASE_ADDR = 0;
    localparam int CNT_W         = 4;
    localparam int IDX_W         = 16;
    localparam int RAY_W         = 8;
    localparam int ROM_LAT       = 2;
    localparam int TDW           = WORDS_PER_TRI * DATA_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               leaf_valid = 1'b0;
    logic               leaf_ready;
    logic [RAY_W-1:0]   leaf_ray_id = '0;
    logic [IDX_W-1:0]   leaf_tri_base = '0;
    logic [CNT_W-1:0]   leaf_tri_count = '0;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_rden;
    logic [DATA_W-1:0]  rom_q = '0;
    logic               tri_valid;
    logic               tri_ready = 1'b1;
    logic [TDW-1:0]     tri_data;
    logic [IDX_W-1:0]   tri_id;
    logic [RAY_W-1:0]   tri_ray_id;
    logic               tri_last;
`ifdef LEAF_TRI_FETCH_STATS_EN
    logic [31:0]        stat_tris;
    logic [31:0]        stat_leaves;
    logic [31:0]        stat_stall;
`endif

    always #5 clk = ~clk;

    leaf_tri_fetch #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_TRI(WORDS_PER_TRI),
        .TRI_BASE_ADDR(TRI_BASE_ADDR), .CNT_W(CNT_W), .IDX_W(IDX_W),
        .RAY_W(RAY_W), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .leaf_valid(leaf_valid), .leaf_ready(leaf_ready),
        .leaf_ray_id(leaf_ray_id), .leaf_tri_base(leaf_tri_base), .leaf_tri_count(leaf_tri_count),
        .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data),
        .tri_id(tri_id), .tri_ray_id(tri_ray_id), .tri_last(tri_last)
`ifdef LEAF_TRI_FETCH_STATS_EN
        ,
        .stat_tris(stat_tris), .stat_leaves(stat_leaves), .stat_stall(stat_stall)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TDW-1:0]   data;
        logic [IDX_W-1:0] id;
        logic [RAY_W-1:0] ray;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tris_exp = 0;
    int   rd_cnt = 0;
    int   reads[int];
    int   rdy_mode = 0;

    task automatic chk(input string name, input logic [TDW-1:0] act, input logic [TDW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rom_val(input longint a);
        return DATA_W'(longint'(32'h1000) + a);
    endfunction

    // Reference: triangle t of a leaf is index (base+t) mod 2^IDX_W, its words sit at
    // TRI_BASE_ADDR + idx*WORDS_PER_TRI + k modulo 2^ADDR_W.
    task automatic push_leaf(input logic [RAY_W-1:0] ray, input logic [IDX_W-1:0] base,
                             input logic [CNT_W-1:0] cnt);
        exp_t   e;
        longint id;
        longint addr;
        for (int t = 0; t < int'(cnt); t++) begin
            id = (longint'(base) + t) % (longint'(1) << IDX_W);
            e.data = '0;
            for (int k = 0; k < WORDS_PER_TRI; k++) begin
                addr = (TRI_BASE_ADDR + id * WORDS_PER_TRI + k) % (longint'(1) << ADDR_W);
                e.data[DATA_W*k +: DATA_W] = rom_val(addr);
            end
            e.id   = IDX_W'(id);
            e.ray  = ray;
            e.last = (t == int'(cnt) - 1);
            exp_q.push_back(e);
        end
        tris_exp += int'(cnt);
    endtask

    // Scene ROM: data for an address is valid two cycles after it; junk when not reading.
    logic [DATA_W-1:0] rom_d1 = '0;
    always @(posedge clk) begin
        if (rom_rden) begin
            reads[int'(rom_addr)] = reads[int'(rom_addr)] + 1;
            rd_cnt = rd_cnt + 1;
        end
        rom_q  <= rom_d1;
        rom_d1 <= rom_rden ? rom_val(longint'(rom_addr)) : DATA_W'($urandom);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) tri_ready = ($urandom_range(0, 99) < 60);
        end
    end

    // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
    logic             prev_stall = 1'b0;
    logic [TDW-1:0]   prev_data;
    logic [IDX_W-1:0] prev_id;
    logic [RAY_W-1:0] prev_ray;
    logic             prev_last;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", tri_valid, 1);
                chk("stall_data", tri_data, prev_data);
                chk("stall_id", tri_id, prev_id);
                chk("stall_ray", tri_ray_id, prev_ray);
                chk("stall_last", tri_last, prev_last);
            end
            if (tri_valid) chk("emit_no_rom", rom_rden, 0);
            if (tri_valid && tri_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tri: got id %0h expected no triangle", tri_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tri_data", tri_data, mon_e.data);
                    chk("tri_id", tri_id, mon_e.id);
                    chk("tri_ray_id", tri_ray_id, mon_e.ray);
                    chk("tri_last", tri_last, mon_e.last);
                end
            end
            prev_stall = tri_valid && !tri_ready;
            prev_data  = tri_data;
            prev_id    = tri_id;
            prev_ray   = tri_ray_id;
            prev_last  = tri_last;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Returns at #1 after the accepting edge (start of cycle 1).
    task automatic send_leaf(input logic [RAY_W-1:0] ray, input logic [IDX_W-1:0] base,
                             input logic [CNT_W-1:0] cnt);
        logic done;
        @(posedge clk);
        #1;
        leaf_valid     = 1'b1;
        leaf_ray_id    = ray;
        leaf_tri_base  = base;
        leaf_tri_count = cnt;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (leaf_ready) begin
                push_leaf(ray, base, cnt);
                @(posedge clk);
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got leaf_ready low expected accept within 3000 cycles");
        end
        #1;
        leaf_valid     = 1'b0;
        leaf_ray_id    = RAY_W'($urandom);
        leaf_tri_base  = IDX_W'($urandom);
        leaf_tri_count = CNT_W'($urandom);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 5000 && !done; n++) begin
            @(negedge clk);
            if (leaf_ready && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d pending triangles expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic early;
        logic seen_v, seen_r, lr_low, found;
        int   bad;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_tri_valid", tri_valid, 0);
        chk("rst_tri_last", tri_last, 0);
        chk("rst_tri_data", tri_data, 0);
        chk("rst_tri_id", tri_id, 0);
        chk("rst_tri_ray_id", tri_ray_id, 0);
        chk("rst_rom_rden", rom_rden, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_leaf_ready", leaf_ready, 1);

        // Single triangle latency: tri_valid first high in cycle 12
        rdy_mode  = 0;
        tri_ready = 1'b1;
        send_leaf(8'd5, 16'd2, 4'd1);
        early = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c < 12) early = early | tri_valid;
            else chk("lat_valid_cycle12", tri_valid, 1);
        end
        chk("lat_not_early", early, 0);
        @(negedge clk);
        chk("lat_leaf_ready_after", leaf_ready, 1);
        chk("lat_valid_dropped", tri_valid, 0);

        // Three triangles from base 0: addresses 0..26 each read once
        reads.delete();
        send_leaf(8'd1, 16'd0, 4'd3);
        wait_idle();
        chk("reads_distinct", reads.size(), 27);
        bad = 0;
        for (int a = 0; a < 27; a++) begin
            if (!reads.exists(a) || reads[a] != 1) bad++;
        end
        chk("reads_once", bad, 0);

        // Count 0: consumed, nothing emitted, no ROM traffic
        do_reset();
        send_leaf(8'd3, 16'd10, 4'd0);
        seen_v = 1'b0; seen_r = 1'b0; lr_low = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            seen_v = seen_v | tri_valid;
            seen_r = seen_r | rom_rden;
            lr_low = lr_low | !leaf_ready;
        end
        chk("cnt0_no_valid", seen_v, 0);
        chk("cnt0_no_rden", seen_r, 0);
        chk("cnt0_ready_low", lr_low, 0);
`ifdef LEAF_TRI_FETCH_STATS_EN
        chk("cnt0_stat_leaves", stat_leaves, 1);
        chk("cnt0_stat_tris", stat_tris, 0);
`endif

        // Backpressure: 20 stalled EMIT cycles on the first of two triangles
        do_reset();
        tri_ready = 1'b0;
        send_leaf(8'd4, 16'd20, 4'd2);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (tri_valid) found = 1'b1;
        end
        chk("stall_reached_emit", found, 1);
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            chk("stall_held_valid", tri_valid, 1);
            chk("stall_no_rden", rom_rden, 0);
        end
        @(posedge clk);
        #1;
        tri_ready = 1'b1;
        wait_idle();
`ifdef LEAF_TRI_FETCH_STATS_EN
        chk("stall_stat_stall", stat_stall, 20);
        chk("stall_stat_tris", stat_tris, 2);
`endif

        // Reset during cycle 5 of FETCH, then a clean leaf
        send_leaf(8'd7, 16'd3, 4'd2);
        repeat (5) @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_tri_valid", tri_valid, 0);
        chk("abort_rom_rden", rom_rden, 0);
        chk("abort_leaf_ready", leaf_ready, 1);
        @(posedge clk);
        #1;
        send_leaf(8'd9, 16'd1, 4'd1);
        wait_idle();

        // Index and address wrap
        send_leaf(8'd2, 16'hFFFF, 4'd2);
        wait_idle();

        // Randomized leaves with random backpressure
        rdy_mode = 1;
        rd_cnt   = 0;
        tris_exp = 0;
        for (int n = 0; n < 25; n++) begin
            send_leaf(RAY_W'($urandom), IDX_W'($urandom), CNT_W'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle();
        rdy_mode = 0;
        chk("rand_rom_reads", rd_cnt, tris_exp * WORDS_PER_TRI);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/leaf_tri_fetch.md
Name: leaf_tri_fetch

Overview:
- Downstream neighbour of the BVH traversal stage in the ray tracer.
- Accepts one leaf descriptor per handshake: ray id, first triangle index and triangle count.
- Fetches each triangle's vertex words from the scene ROM and presents one assembled triangle per valid/ready transfer to the ray-triangle intersection stage.
- Handles backpressure in both directions and marks the last triangle of each leaf.

Parameters:
- ADDR_W, 17: scene ROM word-address width.
- DATA_W, 32: scene ROM word width.
- WORDS_PER_TRI, 9: words per triangle (3 vertices x 3 coords).
- TRI_BASE_ADDR, 0: ROM word address of triangle 0.
- CNT_W, 4: leaf triangle count width (0..15).
- IDX_W, 16: triangle index width.
- RAY_W, 8: ray id width.
- ROM_LAT, 2: scene ROM read latency in cycles (address cycle to data cycle).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- leaf_valid  in  1  descriptor valid
- leaf_ready  out  1  descriptor accepted when valid&ready
- leaf_ray_id  in  RAY_W  ray id
- leaf_tri_base  in  IDX_W  first triangle index
- leaf_tri_count  in  CNT_W  number of triangles in the leaf
- rom_addr  out  ADDR_W  scene ROM address (registered)
- rom_rden  out  1  ROM read enable
- rom_q  in  DATA_W  ROM data, valid ROM_LAT cycles after the address
- tri_valid  out  1  assembled triangle valid
- tri_ready  in  1  downstream accepts when valid&ready
- tri_data  out  WORDS_PER_TRI*DATA_W  word k at bits [DATA_W*k +: DATA_W]
- tri_id  out  IDX_W  triangle index
- tri_ray_id  out  RAY_W  ray id
- tri_last  out  1  last triangle of the leaf

Behaviour:
- Reset:
  - Synchronous, active-high; aborts any operation in flight.
  - State goes to IDLE; all in-flight ROM returns are discarded.
  - Reset values: tri_valid 0, tri_last 0, tri_data 0, tri_id 0, tri_ray_id 0, rom_rden 0, rom_addr 0.
  - leaf_ready is 1 from the first cycle after reset.
- leaf_ready = (state == IDLE), decoded from state only; no combinational path from tri_ready.
- IDLE:
  - On accept, latch ray id, base and count; set cur = base, i = 0.
  - count == 0: consume the descriptor, emit nothing, stay in IDLE.
  - count > 0: go to FETCH.
- FETCH:
  - Total length is WORDS_PER_TRI + ROM_LAT cycles.
  - First WORDS_PER_TRI cycles: rom_rden = 1, rom_addr = TRI_BASE_ADDR + cur*WORDS_PER_TRI + k for k = 0..WORDS_PER_TRI-1.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - A ROM_LAT-deep valid/index shift register captures rom_q into word slot k exactly ROM_LAT cycles after address k.
  - After the last word is captured, go to EMIT.
- EMIT:
  - tri_valid = 1; tri_id = cur; tri_ray_id = latched id; tri_last = (i == count-1).
  - All outputs stay stable until tri_ready.
  - On transfer with tri_last: go to IDLE, tri_valid 0 next cycle.
  - On transfer otherwise: cur++, i++, go to FETCH.
- Latency (defaults):
  - Accept at edge of cycle 0; FETCH issues in cycles 1..9; last word is captured at the end of cycle 11.
  - tri_valid first high in cycle 12.
  - Each further triangle needs 11 FETCH cycles plus at least 1 EMIT cycle.
- No overlap between fetch and emit; at most one leaf in flight.
- cur wraps modulo 2^IDX_W.
- tri_ready held low: the block stalls indefinitely in EMIT with no ROM reads; data is not lost.
- leaf_valid while busy is ignored (leaf_ready 0); upstream must hold the descriptor.

Optional Feature:
- Macro: LEAF_TRI_FETCH_STATS_EN.
- Defined: adds three outputs, all cleared by reset and saturating at all-ones.
  - stat_tris 32-bit: counts triangle transfers.
  - stat_leaves 32-bit: counts accepted descriptors, including count 0.
  - stat_stall 32-bit: counts EMIT cycles with tri_ready low.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- ROM word n preloaded with value 0x1000+n; leaf {ray 5, base 2, count 1} with tri_ready=1 -> tri_valid first high in cycle 12; tri_data words 0x1012..0x101A; tri_id 2; tri_ray_id 5; tri_last 1; leaf_ready back to 1 the following cycle.
- Leaf {base 0, count 3} with tri_ready=1 -> three transfers, tri_id 0,1,2; tri_last only on 2; ROM addresses 0..26 each read exactly once.
- Leaf {count 0} -> no tri_valid, no rom_rden, leaf_ready stays 1; with the stats macro, stat_leaves = 1 and stat_tris = 0.
- Count 2 with tri_ready low for 20 cycles on the first triangle -> tri_data/tri_id stable throughout, rom_rden 0 during the stall; stat_stall = 20 with the macro.
- Reset asserted in cycle 5 of FETCH -> next cycle: tri_valid 0, rom_rden 0, leaf_ready 1; a new leaf {base 1, count 1} then returns words 0x1009..0x1011 uncorrupted by stale ROM data.
- Leaf {base 0xFFFF, count 2} -> tri_id 0xFFFF then 0x0000; addresses wrap modulo 2^17.
